seq_addsub: RTL and testbench

- Parametrised, multi-cycle, sign-magnitude adder/subtractor.
- Processes SLICE bits per clock through one SLICE-bit ripple-carry slice and keeps the carry between cycles.
- Subtraction returns the magnitude |a-b| plus a sign flag. A negative difference is corrected by a second two's-complement pass through the same slice.
- Sits between operand registers and the result consumer. Uses valid/ready handshakes on both sides.

---
 rtl/seq_addsub_if.sv | 27 ++
 rtl/seq_addsub.sv | 224 ++++++++++++++++++++++
 tb/tb_seq_addsub.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub: valid/ready on the input
// side, valid/ready plus status on the output side.
interface seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             sign;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, sign, cout, busy
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, sign, cout, busy
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle sign-magnitude adder/subtractor reusing one SLICE-bit ripple slice.
// Optional macro ADDSUB_SAT_EN: saturate add results to all ones on carry out.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_param_check
    $error("seq_addsub: SLICE must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [SLICE-1:0] op_a_s;
  logic [SLICE-1:0] op_b_s;
  logic [SLICE:0]   sum_s;
  logic             last_s;
  logic             accept_s;

  function automatic logic [SLICE-1:0] slice_get(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    logic [WIDTH-1:0] sh;
    sh = v >> (int'(i) * SLICE);
    return sh[SLICE-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] slice_put(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] i,
                                                 input logic [SLICE-1:0] s);
    logic [WIDTH-1:0] mask;
    mask = WIDTH'({SLICE{1'b1}}) << (int'(i) * SLICE);
    return (v & ~mask) | (WIDTH'(s) << (int'(i) * SLICE));
  endfunction

  assign accept_s = bus.in_valid & in_ready_q;
  assign last_s   = (idx_q == LAST_IDX);

  // Shared ripple slice: a + b_eff in CALC, ~x + carry in NEG.
  always_comb begin
    if (state_q == S_NEG) begin
      op_a_s = ~slice_get(x_q, idx_q);
      op_b_s = {SLICE{1'b0}};
    end else begin
      op_a_s = slice_get(a_q, idx_q);
      op_b_s = slice_get(b_q, idx_q);
    end
    sum_s = (SLICE+1)'(op_a_s) + (SLICE+1)'(op_b_s) + (SLICE+1)'(carry_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_CALC;
        else          state_d = S_IDLE;
      end
      S_CALC: begin
        if (!last_s)                     state_d = S_CALC;
        else if (mode_q && !sum_s[SLICE]) state_d = S_NEG;
        else                             state_d = S_DONE;
      end
      S_NEG: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_NEG;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
        else               state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          mode_d  = bus.mode;
          carry_d = bus.mode;
          idx_d   = {IDX_W{1'b0}};
          x_d     = {WIDTH{1'b0}};
          sign_d  = 1'b0;
          cout_d  = 1'b0;
        end else begin
          idx_d = idx_q;
        end
      end
      S_CALC: begin
        x_d     = slice_put(x_q, idx_q, sum_s[SLICE-1:0]);
        carry_d = sum_s[SLICE];
        idx_d   = idx_q + IDX_W'(1);
        if (last_s) begin
          idx_d = {IDX_W{1'b0}};
          if (!mode_q) begin
            cout_d = sum_s[SLICE];
            sign_d = 1'b0;
`ifdef ADDSUB_SAT_EN
            result_d = sum_s[SLICE] ? {WIDTH{1'b1}} : x_d;
`else
            result_d = x_d;
`endif
          end else if (sum_s[SLICE]) begin
            sign_d   = 1'b0;
            result_d = x_d;
          end else begin
            // a < b: x holds b-a in two's complement form, negate it next pass
            sign_d  = 1'b1;
            carry_d = 1'b1;
          end
        end else begin
          result_d = result_q;
        end
      end
      S_NEG: begin
        x_d     = slice_put(x_q, idx_q, sum_s[SLICE-1:0]);
        carry_d = sum_s[SLICE];
        idx_d   = idx_q + IDX_W'(1);
        if (last_s) begin
          idx_d    = {IDX_W{1'b0}};
          result_d = x_d;
        end else begin
          result_d = result_q;
        end
      end
      S_DONE: begin
        result_d = result_q;
      end
      default: begin
        result_d = result_q;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_CALC) || (state_d == S_NEG);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      x_q         <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      result_q    <= result_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      sign_q      <= sign_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.sign      = sign_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub (WIDTH=8, SLICE=4): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_seq_addsub;

  localparam int W = 8;
  localparam int S = 4;
  localparam int N = W / S;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  seq_addsub_if #(.WIDTH(W)) bus ();

  seq_addsub #(.WIDTH(W), .SLICE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                output logic [W-1:0] r, output logic s, output logic c,
                                output int lat);
    int sum;
    if (!m) begin
      sum = int'(a) + int'(b);
      r   = W'(sum % 256);
      c   = (sum > 255);
      s   = 1'b0;
      lat = N;
`ifdef ADDSUB_SAT_EN
      if (c) r = 8'hFF;
`endif
    end else if (a >= b) begin
      r = a - b; s = 1'b0; c = 1'b0; lat = N;
    end else begin
      r = b - a; s = 1'b1; c = 1'b0; lat = 2 * N;
    end
  endfunction

  // Compare process: every negedge, check DUT outputs against the model.
  logic [W-1:0] exp_r;
  logic         exp_s, exp_c;
  int           exp_lat, acc_cyc, busy_cnt;
  bit           pend, done_w, hs_prev;

  initial begin
    pend = 0; done_w = 0; hs_prev = 0; busy_cnt = 0; acc_cyc = 0; exp_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; done_w = 0; hs_prev = 0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
      end else begin
        if (hs_prev) begin
          chk("post_hs_in_ready",  32'(bus.in_ready),  32'd1);
          chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
          hs_prev = 0;
        end
        if (pend) begin
          if (bus.out_valid) begin
            chk("latency",    32'(cyc - acc_cyc), 32'(exp_lat));
            chk("busy_cycles", 32'(busy_cnt),     32'(exp_lat));
            pend = 0; done_w = 1;
          end else begin
            chk("busy_inflight",     32'(bus.busy),     32'd1);
            chk("in_ready_inflight", 32'(bus.in_ready), 32'd0);
            busy_cnt = busy_cnt + 1;
          end
        end else if (!done_w) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end
        if (done_w) begin
          chk("done_out_valid", 32'(bus.out_valid), 32'd1);
          chk("done_result",    32'(bus.result),    32'(exp_r));
          chk("done_sign",      32'(bus.sign),      32'(exp_s));
          chk("done_cout",      32'(bus.cout),      32'(exp_c));
          chk("done_in_ready",  32'(bus.in_ready),  32'd0);
          chk("done_busy",      32'(bus.busy),      32'd0);
          if (bus.out_ready) begin
            hs_prev = 1; done_w = 0;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          model(bus.a, bus.b, bus.mode, exp_r, exp_s, exp_c, exp_lat);
          acc_cyc  = cyc + 1;
          busy_cnt = 0;
          pend     = 1;
        end
      end
    end
  end

  // Present an operation, scramble inputs after acceptance, wait for out_valid.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          output int lat);
    int t0;
    bit ok;
    bus.a = a; bus.b = b; bus.mode = m; bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) chk("accept_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.mode = 1'($urandom);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.out_valid;
    end
    if (!ok) chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
    lat = cyc - t0;
  endtask

  // Stall in DONE for 'hold' cycles with stray in_valid pulses, then hand off.
  task automatic finish_op(input int hold);
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a = W'($urandom); bus.b = W'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic rm;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_result",   32'(bus.result),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_op(8'h3C, 8'h21, 1'b0, lat);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_res", 32'(bus.result), 32'h5D);
    chk("add_cout", 32'(bus.cout), 32'd0);
    chk("add_sign", 32'(bus.sign), 32'd0);
    finish_op(0);

    start_op(8'hFF, 8'h01, 1'b0, lat);
`ifdef ADDSUB_SAT_EN
    chk("wrap_res", 32'(bus.result), 32'hFF);
`else
    chk("wrap_res", 32'(bus.result), 32'h00);
`endif
    chk("wrap_cout", 32'(bus.cout), 32'd1);
    finish_op(1);

    start_op(8'h50, 8'h23, 1'b1, lat);
    chk("subp_lat", 32'(lat), 32'd2);
    chk("subp_res", 32'(bus.result), 32'h2D);
    chk("subp_sign", 32'(bus.sign), 32'd0);
    finish_op(0);

    start_op(8'h23, 8'h50, 1'b1, lat);
    chk("subn_lat", 32'(lat), 32'd4);
    chk("subn_res", 32'(bus.result), 32'h2D);
    chk("subn_sign", 32'(bus.sign), 32'd1);
    chk("subn_cout", 32'(bus.cout), 32'd0);
    finish_op(0);

    start_op(8'h7A, 8'h7A, 1'b1, lat);
    chk("subz_res", 32'(bus.result), 32'h00);
    chk("subz_sign", 32'(bus.sign), 32'd0);
    finish_op(0);

    start_op(8'h00, 8'hFF, 1'b1, lat);
    chk("subm_res", 32'(bus.result), 32'hFF);
    chk("subm_sign", 32'(bus.sign), 32'd1);
    finish_op(0);

    start_op(8'h12, 8'h34, 1'b0, lat);
    chk("hold_res", 32'(bus.result), 32'h46);
    finish_op(5);
    chk("hold_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Abort a negative subtraction during its NEG pass.
    bus.a = 8'h23; bus.b = 8'h50; bus.mode = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10 && !bus.in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_valid",  32'(bus.out_valid), 32'd0);
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_ready",  32'(bus.in_ready), 32'd1);
    chk("abort_sign",   32'(bus.sign), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start_op(8'h01, 8'h02, 1'b0, lat);
    chk("after_abort_res", 32'(bus.result), 32'h03);
    finish_op(0);

    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      if ((k % 10) == 3) rb = ra;
      if ((k % 10) == 7) begin ra = 8'hFF; rb = W'($urandom_range(1, 255)); end
      start_op(ra, rb, rm, lat);
      finish_op(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
